clock_display_scanner: RTL and testbench



---
 rtl/clock_display_pkg.sv | 29 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/clock_display_scanner.sv | 135 +++++++++++++
 tb/tb_clock_display_scanner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display scanner: digit count, digit slot
// indices and active-high seven-segment patterns ordered {g,f,e,d,c,b,a}.
package clock_display_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    typedef enum logic [2:0] {
        DIG_SEC_ONES = 3'd0,
        DIG_SEC_TENS = 3'd1,
        DIG_MIN_ONES = 3'd2,
        DIG_MIN_TENS = 3'd3,
        DIG_HR_ONES  = 3'd4,
        DIG_HR_TENS  = 3'd5
    } digit_idx_e;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high seven-segment decoder, {g,f,e,d,c,b,a}.
// Codes 10..15 render as a dash.
module bcd_to_7seg
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Digit glyph lookup; non-BCD codes fall through to the dash glyph
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed seven-segment scanner for an HH.MM.SS clock.
// Each frame begins with a snapshot of all six digits; each digit slot
// starts with a blank interval to suppress ghosting.
// Optional: define LEADING_ZERO_BLANK_EN to keep the hours-tens anode off
// whenever the snapshot hours-tens digit is zero.
module clock_display_scanner
    import clock_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] hr_tens,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned    CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [2:0]                      idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      shadow_q, shadow_d;
    logic                            snap;
    logic                            blank;
    logic [3:0]                      digit_sel;
    logic [6:0]                      seg_raw;
    logic [NUM_DIGITS-1:0]           an_act;
    logic [6:0]                      seg_act;
    logic                            dp_act;
    logic [NUM_DIGITS-1:0]           an_q;
    logic [6:0]                      seg_q;
    logic                            dp_q;
    logic                            frame_tick_q;

    assign snap  = (idx_q == DIG_SEC_ONES) && (cnt_q == '0);
    assign blank = (32'(cnt_q) < BLANK_CYCLES);

    // Slot counter and digit index advance
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == DIG_HR_TENS) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Frame-start snapshot of all six digits
    always_comb begin
        shadow_d = shadow_q;
        if (snap) begin
            shadow_d[DIG_SEC_ONES] = sec_ones;
            shadow_d[DIG_SEC_TENS] = sec_tens;
            shadow_d[DIG_MIN_ONES] = min_ones;
            shadow_d[DIG_MIN_TENS] = min_tens;
            shadow_d[DIG_HR_ONES]  = hr_ones;
            shadow_d[DIG_HR_TENS]  = hr_tens;
        end
    end

    // Select the current slot's digit; the snapshot is bypassed so the
    // frame's first slot already sees the freshly captured value
    always_comb begin
        digit_sel = '0;
        case (idx_q)
            DIG_SEC_ONES: digit_sel = shadow_d[DIG_SEC_ONES];
            DIG_SEC_TENS: digit_sel = shadow_d[DIG_SEC_TENS];
            DIG_MIN_ONES: digit_sel = shadow_d[DIG_MIN_ONES];
            DIG_MIN_TENS: digit_sel = shadow_d[DIG_MIN_TENS];
            DIG_HR_ONES:  digit_sel = shadow_d[DIG_HR_ONES];
            DIG_HR_TENS:  digit_sel = shadow_d[DIG_HR_TENS];
            default:      digit_sel = '0;
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .bcd_i (digit_sel),
        .seg_o (seg_raw)
    );

    // Active-high anode, segment and separator values for the next cycle
    always_comb begin
        an_act = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_act[i] = !blank && (idx_q == 3'(i));
        end
        seg_act = blank ? SEG_OFF : seg_raw;
        dp_act  = !blank && ((idx_q == DIG_MIN_ONES) || (idx_q == DIG_HR_ONES));
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == DIG_HR_TENS) && (digit_sel == 4'd0)) begin
            an_act  = '0;
            seg_act = SEG_OFF;
        end
`else
`endif
    end

    // State registers and polarity-adjusted output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            frame_tick_q <= 1'b0;
            an_q         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_q        <= {7{SEG_ACTIVE_LOW}};
            dp_q         <= SEG_ACTIVE_LOW;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frame_tick_q <= snap;
            an_q         <= an_act ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_q        <= seg_act ^ {7{SEG_ACTIVE_LOW}};
            dp_q         <= dp_act ^ SEG_ACTIVE_LOW;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Self-checking bench for clock_display_scanner with a small scan geometry.
// Expected outputs come from a frame-position model and a letter-based glyph
// table; honours LEADING_ZERO_BLANK_EN when defined.
module tb_clock_display_scanner;

    localparam int unsigned RD    = 4;
    localparam int unsigned BC    = 1;
    localparam int unsigned FRAME = 6 * RD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dig [6];
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    int         pos;
    logic [3:0] shadow [6];
    logic [6:0] font [16];
    int         tick_count;

    clock_display_scanner #(
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_ones   (dig[0]),
        .sec_tens   (dig[1]),
        .min_ones   (dig[2]),
        .min_tens   (dig[3]),
        .hr_ones    (dig[4]),
        .hr_tens    (dig[5]),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] letters(input string s);
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        dig[5] = 4'(h / 10); dig[4] = 4'(h % 10);
        dig[3] = 4'(m / 10); dig[2] = 4'(m % 10);
        dig[1] = 4'(s / 10); dig[0] = 4'(s % 10);
    endtask

    // One clock: predict the outputs produced by this edge, then compare.
    task automatic step();
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_ft;
        int         slot, c;
        if (rst) begin
            pos = 0;
            for (int i = 0; i < 6; i++) shadow[i] = 4'd0;
            e_an = '1; e_seg = '1; e_dp = 1'b1; e_ft = 1'b0;
        end else begin
            slot = pos / RD;
            c    = pos % RD;
            if (pos == 0) for (int i = 0; i < 6; i++) shadow[i] = dig[i];
            e_ft = (pos == 0);
            if (c < BC) begin
                e_an = '1; e_seg = '1; e_dp = 1'b1;
            end else begin
                e_an = '1;
                e_an[slot] = 1'b0;
                e_seg = ~font[shadow[slot]];
                e_dp  = !(slot == 2 || slot == 4);
`ifdef LEADING_ZERO_BLANK_EN
                if (slot == 5 && shadow[5] == 4'd0) begin
                    e_an = '1; e_seg = '1;
                end
`endif
            end
            pos = (pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        check_eq("an", 32'(an), 32'(e_an));
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("dp", 32'(dp), 32'(e_dp));
        check_eq("frame_tick", 32'(frame_tick), 32'(e_ft));
        check_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        if (frame_tick === 1'b1) tick_count++;
    endtask

    task automatic run_to_pos(input int target);
        for (int k = 0; k < FRAME && pos != target; k++) step();
    endtask

    initial begin
        string pat [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        for (int i = 0; i < 16; i++) font[i] = (i < 10) ? letters(pat[i]) : letters("g");
        pos = 0;
        tick_count = 0;

        // Reset hold, then steady scan of 12:34:56
        rst = 1'b1;
        set_time(12, 34, 56);
        repeat (3) step();
        rst = 1'b0;
        tick_count = 0;
        repeat (2 * FRAME) step();
        check_eq("ticks_2frames", 32'(tick_count), 32'd2);

        // Mid-frame input change stays hidden until the next snapshot
        run_to_pos(10);
        set_time(23, 59, 59);
        repeat (FRAME - 10 + FRAME) step();

        // Non-BCD seconds digit renders as a dash
        dig[0] = 4'hC;
        repeat (2 * FRAME) step();

        // Reset pulse in the middle of slot 3
        set_time(12, 34, 56);
        run_to_pos(3 * RD + 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (FRAME) step();

        // Zero hours-tens digit
        set_time(9, 5, 7);
        repeat (2 * FRAME) step();

        // Randomised digits and occasional reset pulses
        repeat (800) begin
            if ($urandom_range(7) == 0) dig[$urandom_range(5)] = 4'($urandom_range(15));
            rst = ($urandom_range(63) == 0);
            step();
        end
        rst = 1'b0;
        tick_count = 0;
        run_to_pos(0);
        tick_count = 0;
        repeat (3 * FRAME) step();
        check_eq("ticks_3frames", 32'(tick_count), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
